// File: rtl/rcv_pkg.sv
// Shared types and default constants for the serial frame receiver.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        LOAD   = 3'd5
    } rcv_state_t;

    localparam int RCV_CLKS_PER_BIT = 10;
    localparam int RCV_DATA_BITS    = 8;

endpackage

// File: rtl/rcv_frame_flex_counter.sv
// Generic up-counter with synchronous clear that wraps to 0 after rollover_val.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_enable) begin
            if (count_reg == rollover_val) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign count_out     = count_reg;
    assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/rcv_frame.sv
// Serial frame receiver: start / data (LSB first) / optional even parity / stop.
// Define RCV_PARITY_EN to include the parity bit and parity_error checking.
module rcv_frame
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT  = RCV_CLKS_PER_BIT,
    parameter int NUM_DATA_BITS = RCV_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     serial_in,
    input  logic                     data_read,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     framing_error,
    output logic                     overrun_error,
    output logic                     parity_error
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(NUM_DATA_BITS - 1);

    rcv_state_t               state_reg, state_next;
    logic                     prev_in_reg;
    logic                     armed_reg;
    logic [NUM_DATA_BITS-1:0] shift_reg;
    logic [3:0]               bit_cnt_reg;
    logic [NUM_DATA_BITS-1:0] rx_data_reg;
    logic                     data_ready_reg;
    logic                     framing_error_reg;
    logic                     overrun_error_reg;

    logic [TW-1:0] timer_count;
    logic          timer_roll;
    logic          start_edge;
    logic          mid_sample;
    logic          timer_clear;
    logic          shift_en;
    logic          frame_err_set;
    logic          load_en;

    flex_counter #(.WIDTH(TW)) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (state_reg != IDLE),
        .rollover_val (LAST_CNT),
        .count_out    (timer_count),
        .rollover_flag(timer_roll)
    );

    // armed_reg blocks the first cycle after reset so a line held low is not a start edge
    assign start_edge = armed_reg & prev_in_reg & ~serial_in;
    assign mid_sample = (timer_count == HALF_BIT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start_edge) state_next = START;
            START:  if (mid_sample) state_next = serial_in ? IDLE : DATA;
            DATA: begin
                if (timer_roll && bit_cnt_reg == LAST_BIT) begin
`ifdef RCV_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: if (timer_roll) state_next = STOP;
            STOP:   if (timer_roll) state_next = serial_in ? LOAD : IDLE;
            LOAD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        timer_clear   = 1'b0;
        shift_en      = 1'b0;
        frame_err_set = 1'b0;
        load_en       = 1'b0;
        case (state_reg)
            IDLE:  timer_clear   = start_edge;
            START: timer_clear   = mid_sample;
            DATA:  shift_en      = timer_roll;
            STOP:  frame_err_set = timer_roll & ~serial_in;
            LOAD:  load_en       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_in_reg <= 1'b1;
            armed_reg   <= 1'b0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            prev_in_reg <= serial_in;
            armed_reg   <= 1'b1;
            if (state_reg == START && mid_sample) begin
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {serial_in, shift_reg[NUM_DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_reg       <= '0;
            data_ready_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_error_reg <= 1'b0;
        end else if (load_en) begin
            rx_data_reg       <= shift_reg;
            data_ready_reg    <= 1'b1;
            framing_error_reg <= 1'b0;
            if (data_read) begin
                overrun_error_reg <= 1'b0;
            end else if (data_ready_reg) begin
                overrun_error_reg <= 1'b1;
            end
        end else begin
            if (frame_err_set) begin
                framing_error_reg <= 1'b1;
            end
            if (data_read) begin
                data_ready_reg    <= 1'b0;
                overrun_error_reg <= 1'b0;
            end
        end
    end

`ifdef RCV_PARITY_EN
    logic parity_bit_reg;
    logic parity_error_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_bit_reg   <= 1'b0;
            parity_error_reg <= 1'b0;
        end else begin
            if (state_reg == PARITY && timer_roll) begin
                parity_bit_reg <= serial_in;
            end
            if (load_en) begin
                parity_error_reg <= (^shift_reg) ^ parity_bit_reg;
            end
        end
    end

    assign parity_error = parity_error_reg;
`else
    assign parity_error = 1'b0;
`endif

    assign rx_data       = rx_data_reg;
    assign data_ready    = data_ready_reg;
    assign framing_error = framing_error_reg;
    assign overrun_error = overrun_error_reg;

endmodule

// File: tb/tb_rcv_frame.sv
// Self-checking bench for rcv_frame: directed frame table, corner sequences and random frames
// compared against a frame-level behavioural model. Honours RCV_PARITY_EN like the design.
module tb_rcv_frame;

    localparam int C = 10;
    localparam int N = 8;

    logic         tb_clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         serial_in = 1'b1;
    logic         data_read = 1'b0;
    logic [N-1:0] rx_data;
    logic         data_ready;
    logic         framing_error;
    logic         overrun_error;
    logic         parity_error;

    int checks = 0;
    int errors = 0;

    // frame-level model of the visible outputs
    logic [N-1:0] m_data = '0;
    logic         m_ready = 1'b0;
    logic         m_fe = 1'b0;
    logic         m_ov = 1'b0;
    logic         m_pe = 1'b0;

    always #5 tb_clk = ~tb_clk;

    rcv_frame #(.CLKS_PER_BIT(C), .NUM_DATA_BITS(N)) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .parity_error (parity_error)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par;
        logic       read_before;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (C) @(posedge tb_clk);
        #1;
    endtask

    task automatic do_read();
        serial_in = 1'b1;
        data_read = 1'b1;
        @(posedge tb_clk);
        #1;
        data_read = 1'b0;
        m_ready = 1'b0;
        m_ov = 1'b0;
    endtask

    // drives one frame; checks nothing is loaded before the stop bit is sampled
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < N; i++) send_bit(data[i]);
`ifdef RCV_PARITY_EN
        send_bit(par);
`endif
        chk("pre_stop_ready", data_ready, m_ready);
        chk("pre_stop_data", rx_data, m_data);
        send_bit(stop);
    endtask

    task automatic model_frame(input logic [7:0] data, input logic stop, input logic par);
        if (stop) begin
            if (m_ready) m_ov = 1'b1;
            m_data = data;
            m_ready = 1'b1;
            m_fe = 1'b0;
`ifdef RCV_PARITY_EN
            m_pe = (^data) ^ par;
`endif
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rx_data"}, rx_data, m_data);
        chk({tag, "_ready"}, data_ready, m_ready);
        chk({tag, "_fe"}, framing_error, m_fe);
        chk({tag, "_ov"}, overrun_error, m_ov);
        chk({tag, "_pe"}, parity_error, m_pe);
    endtask

    vec_t vecs[5];

    initial begin
        logic [7:0] d;
        logic       s, p, last_stop;
        int         gap;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};

        #2 n_rst = 1'b0;
        #1;
        check_model("reset");
        repeat (2) @(posedge tb_clk);
        #1 n_rst = 1'b1;
        idle_cycles(5);

        // directed table
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].read_before) do_read();
            idle_cycles(2);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par);
            model_frame(vecs[i].data, vecs[i].stop, vecs[i].par);
            chk("tbl_rx_data", rx_data, vecs[i].exp_data);
            chk("tbl_ready", data_ready, vecs[i].exp_ready);
            chk("tbl_fe", framing_error, vecs[i].exp_fe);
            chk("tbl_ov", overrun_error, vecs[i].exp_ov);
            chk("tbl_pe", parity_error, 1'b0);
            $display("table %0d data=%02h stop=%0d rx_data=%02h ready=%0d fe=%0d ov=%0d",
                     i, vecs[i].data, vecs[i].stop, rx_data, data_ready, framing_error, overrun_error);
        end

        // read pulse clears ready and overrun, data kept
        do_read();
        idle_cycles(1);
        check_model("read_clear");
        $display("read rx_data=%02h ready=%0d ov=%0d", rx_data, data_ready, overrun_error);

        // false start: 3 low cycles then high
        serial_in = 1'b0;
        repeat (3) @(posedge tb_clk);
        #1;
        idle_cycles(20);
        check_model("false_start");
        send_frame(8'h6B, 1'b1, 1'b1);
        model_frame(8'h6B, 1'b1, 1'b1);
        check_model("after_false");
        $display("false start then frame rx_data=%02h ready=%0d", rx_data, data_ready);

`ifdef RCV_PARITY_EN
        do_read();
        idle_cycles(2);
        send_frame(8'h07, 1'b1, 1'b0);
        model_frame(8'h07, 1'b1, 1'b0);
        chk("par_bad_pe", parity_error, 1'b1);
        chk("par_bad_data", rx_data, 8'h07);
        $display("parity frame 07 par=0 pe=%0d rx_data=%02h", parity_error, rx_data);
        do_read();
        idle_cycles(2);
        send_frame(8'h07, 1'b1, 1'b1);
        model_frame(8'h07, 1'b1, 1'b1);
        chk("par_good_pe", parity_error, 1'b0);
        $display("parity frame 07 par=1 pe=%0d rx_data=%02h", parity_error, rx_data);
`endif

        // random frames, including back-to-back and framing errors
        last_stop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            s = ($urandom % 5) != 0;
            p = 1'($urandom % 2);
`ifndef RCV_PARITY_EN
            p = 1'b0;
`endif
            gap = last_stop ? int'($urandom % 3) : 1 + int'($urandom % 3);
            if ($urandom % 3 == 0) do_read();
            if (gap > 0) idle_cycles(gap);
            send_frame(d, s, p);
            model_frame(d, s, p);
            check_model("rand");
            last_stop = s;
            $display("rand %0d data=%02h stop=%0d par=%0d rx_data=%02h ready=%0d fe=%0d ov=%0d pe=%0d",
                     i, d, s, p, rx_data, data_ready, framing_error, overrun_error, parity_error);
        end

        // make outputs nonzero, then reset during the 4th data bit with the line low
        idle_cycles(2);
        send_frame(8'hC3, 1'b1, 1'b0);
        model_frame(8'hC3, 1'b1, 1'b0);
        idle_cycles(2);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        serial_in = 1'b0;
        repeat (5) @(posedge tb_clk);
        #1 n_rst = 1'b0;
        #1;
        m_data = '0; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        check_model("mid_reset");
        repeat (2) @(posedge tb_clk);
        #1 n_rst = 1'b1;
        repeat (15) @(posedge tb_clk);
        #1;
        check_model("low_after_reset");
        idle_cycles(12);
        send_frame(8'h5A, 1'b1, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0);
        chk("post_reset_data", rx_data, 8'h5A);
        check_model("post_reset");
        $display("post reset frame rx_data=%02h ready=%0d", rx_data, data_ready);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rcv_frame.md
RCV_FRAME -- requirements
Module: rcv_frame

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit period; legal range 4..255.
REQ-002 Parameter NUM_DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 serial_in  input  1  serial line, already synchronized by the upstream sync_high stage; idle high.
REQ-006 data_read  input  1  consumer acknowledge; single-cycle pulse that clears data_ready.
REQ-007 rx_data  output  NUM_DATA_BITS  last successfully received data word.
REQ-008 data_ready  output  1  rx_data holds unread data.
REQ-009 framing_error  output  1  last frame had stop bit = 0.
REQ-010 overrun_error  output  1  a new word overwrote an unread word.
REQ-011 parity_error  output  1  last frame failed even-parity check (see Configuration).

Function
REQ-012 Internal prev_in register samples serial_in each cycle; start edge = prev_in==1 && serial_in==0, detected only in IDLE.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP, LOAD; encoding in package type rcv_state_t.
REQ-014 IDLE->START on start edge; bit timer cleared to 0 in the same cycle.
REQ-015 START: sample serial_in when timer reaches CLKS_PER_BIT/2 (integer division, mid-bit); if 1 (false start) -> IDLE with no output change; if 0 -> DATA with timer restarted.
REQ-016 DATA: sample every CLKS_PER_BIT cycles after the start mid-sample; bits shifted in LSB first; after NUM_DATA_BITS samples -> PARITY if compiled in, else STOP.
REQ-017 PARITY: one sample CLKS_PER_BIT after the last data sample -> STOP.
REQ-018 STOP: one sample CLKS_PER_BIT after the previous sample; stop==1 -> LOAD; stop==0 -> framing_error<=1, rx_data and data_ready unchanged, -> IDLE.
REQ-019 LOAD (exactly one cycle): rx_data<=shift register, data_ready<=1, framing_error<=0, -> IDLE; data_ready visible 1 cycle after the stop sample cycle.
REQ-020 Overrun: in LOAD, if data_ready==1 and data_read==0 then overrun_error<=1; rx_data is still overwritten.
REQ-021 data_read==1 outside LOAD clears data_ready and overrun_error on the next edge; data_read during LOAD: data_ready stays 1, overrun_error<=0.
REQ-022 A start edge arriving in any non-IDLE state is ignored; after STOP or LOAD, IDLE accepts a start edge on the very next cycle (back-to-back frames).
REQ-023 Bit timer width is $clog2(CLKS_PER_BIT)+1; it counts 0..CLKS_PER_BIT-1 and wraps without overflow.
REQ-024 rx_data, error flags and data_ready are registered outputs; no combinational path from inputs to outputs.

Reset
REQ-025 n_rst==0 forces state=IDLE, timer=0, shift register=0, prev_in=1, rx_data=0, data_ready=0, framing_error=0, overrun_error=0, parity_error=0, immediately and asynchronously.
REQ-026 Reset mid-frame abandons the frame; after release the block waits for a new start edge; a line held low across release is not treated as a start edge.

Configuration
REQ-027 Macro RCV_PARITY_EN: when defined, frame = start, data, even-parity bit, stop; in LOAD, parity_error<=(XOR of data bits and parity bit)==1; data is still loaded.
REQ-028 Without RCV_PARITY_EN: no PARITY state transitions, frame = start, data, stop; parity_error is tied to 0.

Structure
REQ-029 Package rcv_pkg holds rcv_state_t and default constants RCV_CLKS_PER_BIT=10 and RCV_DATA_BITS=8.
REQ-030 Bit timer is a sub-module flex_counter (parameterized width, clear, count_enable, rollover_val, rollover_flag); the FSM, shift register and output registers stay in rcv_frame.

Verification (CLKS_PER_BIT=10, NUM_DATA_BITS=8)
REQ-031 Frame 0xA5 with stop=1 -> rx_data==8'hA5 and data_ready==1 one cycle after the stop sample; all error flags 0.
REQ-032 serial_in low for 3 cycles then high -> false start; state returns to IDLE; no output changes.
REQ-033 Frame 0x3C with stop=0 -> framing_error==1, data_ready and rx_data unchanged; the next good frame 0x01 clears framing_error.
REQ-034 Frames 0x11 then 0x22 with no data_read -> rx_data==8'h22, overrun_error==1; a data_read pulse then clears data_ready and overrun_error.
REQ-035 n_rst asserted during the 4th data bit -> all outputs 0 immediately; a following frame 0x5A is received correctly.
REQ-036 With RCV_PARITY_EN defined: frame 0x07 with parity bit 0 -> parity_error==1 and rx_data==8'h07; with parity bit 1 -> parity_error==0.
